// File: rtl/matrix_window_ctrl.sv
// matrix_window_ctrl: frame/line sequencing for a 3x3 matrix generator.
// Tracks the position of the next pixel, decides which accepted pixels
// complete a fully interior 3x3 window, and delays each window event so it
// lines up with the generator's internal pipeline.
//
// Handshake: wr_en qualifies exactly one pixel in the cycle it is high; there
// is no backpressure, so every wr_en seen in PRIME/ACTIVE is consumed.
module matrix_window_ctrl #(
    parameter int IMG_W    = 800,
    parameter int IMG_H    = 480,
    parameter int PIPE_DLY = 3
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        pre_vsync,
    input  logic        pre_href,
    input  logic        wr_en,
    output logic        buf_clr,
    output logic        busy,
    output logic [1:0]  state,
    output logic [11:0] col_cnt,
    output logic [10:0] row_cnt,
    output logic        win_valid,
    output logic [11:0] win_x,
    output logic [10:0] win_y,
    output logic        frame_done,
    output logic        frame_abort,
    output logic        line_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // One delayed window event; 'last' marks the final window of the frame.
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [11:0] x;
        logic [10:0] y;
    } win_ent_t;

    localparam logic [11:0] COL_LAST   = 12'(IMG_W - 1);
    localparam logic [10:0] ROW_LAST   = 11'(IMG_H - 1);
    localparam logic [10:0] ROW_PRIMED = 11'd2;

    state_t                     state_q, state_d;
    logic                       vsync_q, href_q;
    logic [11:0]                col_q, col_d;
    logic [10:0]                row_q, row_d;
    logic                       line_err_q, line_err_d;
    logic                       buf_clr_q, frame_abort_q;
    win_ent_t [PIPE_DLY-1:0]    pipe_q;
    win_ent_t                   new_ent;

    logic in_frame, vs_edge, href_fall, pix_acc, last_pix, short_close;

    assign in_frame    = (state_q == ST_PRIME) || (state_q == ST_ACTIVE);
    assign vs_edge     = pre_vsync && !vsync_q;
    assign href_fall   = href_q && !pre_href;
    assign pix_acc     = in_frame && wr_en && !vs_edge;
    assign last_pix    = pix_acc && (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign short_close = in_frame && !vs_edge && !wr_en && href_fall && (col_q != 12'd0);

    // Input history for edge detection; vsync history resets high so a
    // vsync already asserted when reset releases is not seen as an edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vsync_q <= 1'b1;
            href_q  <= 1'b0;
        end else begin
            vsync_q <= pre_vsync;
            href_q  <= pre_href;
        end
    end

    // FSM state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // FSM next state: vsync edge always restarts; PRIME waits for two lines.
    always_comb begin
        state_d = state_q;
        if (vs_edge) begin
            state_d = ST_PRIME;
        end else begin
            case (state_q)
                ST_PRIME: begin
                    if (last_pix)                 state_d = ST_DONE;
                    else if (row_d == ROW_PRIMED) state_d = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (last_pix) state_d = ST_DONE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        busy  = in_frame;
        state = state_q;
    end

    // Pixel position and short-line bookkeeping.
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        line_err_d = line_err_q;
        if (vs_edge) begin
            col_d      = 12'd0;
            row_d      = 11'd0;
            line_err_d = 1'b0;
        end else if (pix_acc) begin
            if (col_q == COL_LAST) begin
                col_d = 12'd0;
                row_d = (row_q == ROW_LAST) ? 11'd0 : row_q + 11'd1;
            end else begin
                col_d = col_q + 12'd1;
            end
        end else if (short_close) begin
            line_err_d = 1'b1;
            col_d      = 12'd0;
            // A short final line cannot push the row past the frame.
            if (row_q != ROW_LAST) row_d = row_q + 11'd1;
        end
    end

    // Counter, sticky error and single-cycle pulse registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            col_q         <= 12'd0;
            row_q         <= 11'd0;
            line_err_q    <= 1'b0;
            buf_clr_q     <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            line_err_q    <= line_err_d;
            buf_clr_q     <= vs_edge;
            frame_abort_q <= vs_edge && in_frame;
        end
    end

    // Window event for the pixel accepted this cycle (centre is one up/left).
    always_comb begin
        new_ent = '0;
        if (pix_acc && (col_q >= 12'd2) && (row_q >= 11'd2)) begin
            new_ent.valid = 1'b1;
            new_ent.last  = last_pix;
            new_ent.x     = col_q - 12'd1;
            new_ent.y     = row_q - 11'd1;
        end
    end

    // Delay line matching the generator latency; an abort discards it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pipe_q <= '0;
        end else if (vs_edge && in_frame) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= new_ent;
            for (int i = 1; i < PIPE_DLY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign buf_clr     = buf_clr_q;
    assign frame_abort = frame_abort_q;
    assign line_err    = line_err_q;
    assign col_cnt     = col_q;
    assign row_cnt     = row_q;
    assign win_valid   = pipe_q[PIPE_DLY-1].valid;
    assign win_x       = pipe_q[PIPE_DLY-1].x;
    assign win_y       = pipe_q[PIPE_DLY-1].y;
    assign frame_done  = pipe_q[PIPE_DLY-1].valid && pipe_q[PIPE_DLY-1].last;

endmodule

// File: tb/tb_matrix_window_ctrl.sv
// Directed bench for matrix_window_ctrl with a 4x3 image and 3-cycle pipe.
module tb_matrix_window_ctrl;
  localparam int IMG_W    = 4;
  localparam int IMG_H    = 3;
  localparam int PIPE_DLY = 3;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        pre_vsync = 1'b0;
  logic        pre_href  = 1'b0;
  logic        wr_en     = 1'b0;
  logic        buf_clr, busy, win_valid, frame_done, frame_abort, line_err;
  logic [1:0]  state;
  logic [11:0] col_cnt, win_x;
  logic [10:0] row_cnt, win_y;

  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  matrix_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIPE_DLY(PIPE_DLY)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .pre_vsync  (pre_vsync),
    .pre_href   (pre_href),
    .wr_en      (wr_en),
    .buf_clr    (buf_clr),
    .busy       (busy),
    .state      (state),
    .col_cnt    (col_cnt),
    .row_cnt    (row_cnt),
    .win_valid  (win_valid),
    .win_x      (win_x),
    .win_y      (win_y),
    .frame_done (frame_done),
    .frame_abort(frame_abort),
    .line_err   (line_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one clock; outputs sampled 1ns after the rising edge
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".state"},       32'(state),       32'd0);
    chk({tag, ".col"},         32'(col_cnt),     32'd0);
    chk({tag, ".row"},         32'(row_cnt),     32'd0);
    chk({tag, ".buf_clr"},     32'(buf_clr),     32'd0);
    chk({tag, ".busy"},        32'(busy),        32'd0);
    chk({tag, ".win_valid"},   32'(win_valid),   32'd0);
    chk({tag, ".win_x"},       32'(win_x),       32'd0);
    chk({tag, ".win_y"},       32'(win_y),       32'd0);
    chk({tag, ".frame_done"},  32'(frame_done),  32'd0);
    chk({tag, ".frame_abort"}, 32'(frame_abort), 32'd0);
    chk({tag, ".line_err"},    32'(line_err),    32'd0);
  endtask

  // low cycle then high cycle on vsync; outputs afterwards show the edge result
  task automatic vsync_edge();
    wr_en = 1'b0;
    pre_vsync = 1'b0;
    step();
    pre_vsync = 1'b1;
    step();
  endtask

  initial begin
    int n;
    int exp_st;
    logic exp_v;

    // reset with vsync already high
    sys_rst_n = 1'b0;
    pre_vsync = 1'b1;
    repeat (2) step();
    chk_reset_outs("rst");
    sys_rst_n = 1'b1;
    repeat (3) step();
    chk("rst_vs_high.state",   32'(state),   32'd0);
    chk("rst_vs_high.buf_clr", 32'(buf_clr), 32'd0);

    // wr_en in IDLE is ignored
    wr_en = 1'b1;
    repeat (2) step();
    wr_en = 1'b0;
    chk("idle.col",   32'(col_cnt),   32'd0);
    chk("idle.row",   32'(row_cnt),   32'd0);
    chk("idle.win",   32'(win_valid), 32'd0);
    chk("idle.state", 32'(state),     32'd0);

    // full frame, contiguous pixels
    vsync_edge();
    chk("f1.buf_clr", 32'(buf_clr),     32'd1);
    chk("f1.state",   32'(state),       32'd1);
    chk("f1.busy",    32'(busy),        32'd1);
    chk("f1.abort",   32'(frame_abort), 32'd0);
    chk("f1.col0",    32'(col_cnt),     32'd0);
    chk("f1.row0",    32'(row_cnt),     32'd0);
    pre_href = 1'b1;
    wr_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      n = i + 1;
      exp_st = (n == 12) ? 3 : (n >= 8) ? 2 : 1;
      chk("f1.px.col",   32'(col_cnt),   32'(n % 4));
      chk("f1.px.row",   32'(row_cnt),   32'((n == 12) ? 0 : n / 4));
      chk("f1.px.state", 32'(state),     32'(exp_st));
      chk("f1.px.win",   32'(win_valid), 32'd0);
      if (i == 0) chk("f1.buf_clr_end", 32'(buf_clr), 32'd0);
    end
    wr_en = 1'b0;
    pre_href = 1'b0;
    step();
    chk("f1.w0.valid", 32'(win_valid),  32'd1);
    chk("f1.w0.x",     32'(win_x),      32'd1);
    chk("f1.w0.y",     32'(win_y),      32'd1);
    chk("f1.w0.done",  32'(frame_done), 32'd0);
    step();
    chk("f1.w1.valid", 32'(win_valid),  32'd1);
    chk("f1.w1.x",     32'(win_x),      32'd2);
    chk("f1.w1.y",     32'(win_y),      32'd1);
    chk("f1.w1.done",  32'(frame_done), 32'd1);
    step();
    chk("f1.after.valid", 32'(win_valid),  32'd0);
    chk("f1.after.done",  32'(frame_done), 32'd0);
    chk("f1.after.state", 32'(state),      32'd3);
    chk("f1.after.busy",  32'(busy),       32'd0);
    chk("f1.after.lerr",  32'(line_err),   32'd0);

    // wr_en in DONE is ignored
    wr_en = 1'b1;
    repeat (2) step();
    wr_en = 1'b0;
    chk("done.col",   32'(col_cnt),   32'd0);
    chk("done.row",   32'(row_cnt),   32'd0);
    chk("done.state", 32'(state),     32'd3);
    chk("done.win",   32'(win_valid), 32'd0);

    // abort after 6 pixels
    vsync_edge();
    chk("ab.buf_clr", 32'(buf_clr),     32'd1);
    chk("ab.abort0",  32'(frame_abort), 32'd0);
    pre_href = 1'b1;
    wr_en = 1'b1;
    repeat (6) step();
    wr_en = 1'b0;
    chk("ab.col6",   32'(col_cnt), 32'd2);
    chk("ab.row6",   32'(row_cnt), 32'd1);
    chk("ab.state6", 32'(state),   32'd1);
    vsync_edge();
    chk("ab.abort",   32'(frame_abort), 32'd1);
    chk("ab.clr",     32'(buf_clr),     32'd1);
    chk("ab.col",     32'(col_cnt),     32'd0);
    chk("ab.row",     32'(row_cnt),     32'd0);
    chk("ab.state",   32'(state),       32'd1);
    step();
    chk("ab.abort_end", 32'(frame_abort), 32'd0);
    chk("ab.clr_end",   32'(buf_clr),     32'd0);
    chk("ab.win",       32'(win_valid),   32'd0);

    // short line sets sticky line_err
    wr_en = 1'b1;
    repeat (3) step();
    wr_en = 1'b0;
    pre_href = 1'b0;
    step();
    chk("le.flag", 32'(line_err), 32'd1);
    chk("le.col",  32'(col_cnt),  32'd0);
    chk("le.row",  32'(row_cnt),  32'd1);
    pre_href = 1'b1;
    step();
    chk("le.hold", 32'(line_err), 32'd1);
    wr_en = 1'b1;
    repeat (4) step();
    wr_en = 1'b0;
    chk("le.row2",  32'(row_cnt),  32'd2);
    chk("le.col2",  32'(col_cnt),  32'd0);
    chk("le.state", 32'(state),    32'd2);
    chk("le.hold2", 32'(line_err), 32'd1);

    // gapped pixels in ACTIVE: pixel at steps 1,4,7,10; windows at 9 and 12
    for (int j = 1; j <= 12; j++) begin
      wr_en = (j % 3 == 1);
      step();
      exp_v = (j == 9) || (j == 12);
      chk("gap.valid", 32'(win_valid),  32'(exp_v));
      chk("gap.done",  32'(frame_done), 32'(j == 12));
      if (j == 9) begin
        chk("gap.x9", 32'(win_x), 32'd1);
        chk("gap.y9", 32'(win_y), 32'd1);
      end
      if (j == 12) begin
        chk("gap.x12", 32'(win_x), 32'd2);
        chk("gap.y12", 32'(win_y), 32'd1);
      end
    end
    wr_en = 1'b0;
    chk("gap.state", 32'(state),    32'd3);
    chk("gap.lerr",  32'(line_err), 32'd1);
    vsync_edge();
    chk("le.cleared",   32'(line_err),    32'd0);
    chk("le.clr_pulse", 32'(buf_clr),     32'd1);
    chk("le.no_abort",  32'(frame_abort), 32'd0);

    // abort in ACTIVE with a window pending in the pipe
    pre_vsync = 1'b0;
    wr_en = 1'b1;
    repeat (11) step();
    wr_en = 1'b0;
    chk("abp.state", 32'(state),   32'd2);
    chk("abp.col",   32'(col_cnt), 32'd3);
    pre_vsync = 1'b1;
    step();
    chk("abp.abort", 32'(frame_abort), 32'd1);
    chk("abp.state", 32'(state),       32'd1);
    for (int j = 0; j < 4; j++) begin
      chk("abp.win",  32'(win_valid),  32'd0);
      chk("abp.done", 32'(frame_done), 32'd0);
      step();
    end

    // reset mid-ACTIVE with a window pending
    wr_en = 1'b1;
    repeat (11) step();
    wr_en = 1'b0;
    chk("rm.state", 32'(state), 32'd2);
    sys_rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_mid");
    repeat (2) step();
    sys_rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step();
      chk("rm.win",   32'(win_valid), 32'd0);
      chk("rm.state", 32'(state),     32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
